// File: rtl/multi_hex_display_if.sv
// Control bus for the multiplexed hex display: value to show plus live display options.
// load is a single-cycle strobe with no backpressure: data is taken on every rising edge where load=1.
interface multi_hex_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic                    load;
    logic [3:0]              state;
    logic                    show_state;
    logic                    blank_lz;
    logic                    blink_en;
    logic [NUM_DIGITS-1:0]   dp_mask;

    modport master (
        output data, load, state, show_state, blank_lz, blink_en, dp_mask
    );

    modport slave (
        input data, load, state, show_state, blank_lz, blink_en, dp_mask
    );
endinterface

// File: rtl/multi_hex_display.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with
// tear-free frame updates, leading-zero blanking, state digit and blinking.
module multi_hex_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_hex_display_if.slave    bus,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [7:0]            catode,
    output logic                  frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] LAST_FRM = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           fcnt;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] disp;

    logic                    wrap;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS-1:0]   sel;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    cur_dp;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign wrap     = (cnt == LAST_CNT);
    assign boundary = wrap && (idx == LAST_IDX);

    // Zero run scans from the top digit down; the state digit is not data and is skipped.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (!(bus.show_state && j == NUM_DIGITS - 1)) begin
                zero_run     = zero_run && (disp[j*4 +: 4] == 4'h0);
                blank_vec[j] = bus.blank_lz && zero_run;
            end
        end
    end

    always_comb begin
        sel       = '0;
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx == IW'(j)) begin
                sel[j]    = 1'b1;
                cur_nib   = disp[j*4 +: 4];
                cur_blank = blank_vec[j];
                cur_dp    = bus.dp_mask[j];
            end
        end
        if (bus.show_state && idx == LAST_IDX) begin
            cur_nib = bus.state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            pending    <= '0;
            disp       <= '0;
            anode      <= '1;
            catode     <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            frame_done <= boundary;
            if (wrap) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end

            if (bus.load) begin
                pending <= bus.data;
            end
            // A load landing on the boundary bypasses pending so it shows this frame.
            if (boundary) begin
                disp <= bus.load ? bus.data : pending;
            end

            if (!bus.blink_en) begin
                fcnt  <= '0;
                phase <= 1'b0;
            end else if (boundary) begin
                if (fcnt == LAST_FRM) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end

            anode  <= (bus.blink_en && phase) ? '1 : ~sel;
            catode <= {~cur_dp, cur_blank ? 7'h7F : seg7(cur_nib)};
        end
    end
endmodule

// File: tb/tb_multi_hex_display.sv
// Directed bench for multi_hex_display with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_multi_hex_display;
    logic       clk;
    logic       reset;
    logic [3:0] anode;
    logic [7:0] catode;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    multi_hex_display_if #(.NUM_DIGITS(4)) bus ();

    multi_hex_display #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .anode     (anode),
        .catode    (catode),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cat packs expected catode per digit as {d3, d2, d1, d0}
    typedef struct packed {
        logic [15:0] data;
        logic        ss;
        logic [3:0]  st;
        logic        bl;
        logic [3:0]  dp;
        logic [31:0] cat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample positions from..to of a 16-cycle frame; pos 0 is the first cycle of digit 0.
    task automatic run(input int from, input int to, input logic [31:0] cat, input logic off,
                       input string name);
        int d;
        logic [3:0] one;
        for (int p = from; p <= to; p++) begin
            @(negedge clk);
            d   = p / 4;
            one = 4'b0001 << d;
            chk($sformatf("%s anode p%0d", name, p), {28'h0, anode}, {28'h0, off ? 4'hF : ~one});
            chk($sformatf("%s catode p%0d", name, p), {24'h0, catode}, {24'h0, cat[d*8 +: 8]});
            chk($sformatf("%s frame_done p%0d", name, p), {31'h0, frame_done}, {31'h0, p == 15});
        end
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        chk($sformatf("%s frame_done wait", name), {31'h0, frame_done}, 32'h1);
    endtask

    task automatic pulse_load(input logic [15:0] d);
        bus.data = d;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic set_flags(input logic ss, input logic [3:0] st, input logic bl, input logic [3:0] dp);
        bus.show_state = ss;
        bus.state      = st;
        bus.blank_lz   = bl;
        bus.dp_mask    = dp;
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 1'b0, 4'h0, 1'b0, 4'h0, 32'hF9A4888E};
        vecs[1] = '{16'h0005, 1'b0, 4'h0, 1'b1, 4'h0, 32'hFFFFFF92};
        vecs[2] = '{16'h0005, 1'b0, 4'h0, 1'b0, 4'h0, 32'hC0C0C092};
        vecs[3] = '{16'h0007, 1'b1, 4'h3, 1'b1, 4'h0, 32'hB0FFFFF8};
        vecs[4] = '{16'h0300, 1'b0, 4'h0, 1'b1, 4'hA, 32'h7FB040C0};
        vecs[5] = '{16'h0000, 1'b0, 4'h0, 1'b1, 4'h0, 32'hFFFFFFC0};
        vecs[6] = '{16'h89B4, 1'b0, 4'h0, 1'b0, 4'h0, 32'h80908399};
        vecs[7] = '{16'h6000, 1'b1, 4'h0, 1'b1, 4'h0, 32'hC0FFFFC0};

        reset        = 1'b0;
        bus.data     = '0;
        bus.load     = 1'b0;
        bus.blink_en = 1'b0;
        set_flags(1'b0, 4'h0, 1'b0, 4'h0);

        repeat (3) @(negedge clk);
        chk("reset anode", {28'h0, anode}, 32'hF);
        chk("reset catode", {24'h0, catode}, 32'hFF);
        chk("reset frame_done", {31'h0, frame_done}, 32'h0);

        reset = 1'b1;
        run(0, 15, 32'hC0C0C0C0, 1'b0, "post_reset");

        for (int i = 0; i < 8; i++) begin
            set_flags(vecs[i].ss, vecs[i].st, vecs[i].bl, vecs[i].dp);
            pulse_load(vecs[i].data);
            wait_fd($sformatf("vec%0d", i));
            run(0, 15, vecs[i].cat, 1'b0, $sformatf("vec%0d", i));
        end

        // Mid-frame load must not tear the frame in progress.
        set_flags(1'b0, 4'h0, 1'b0, 4'h0);
        wait_fd("tear");
        run(0, 5, 32'h82C0C0C0, 1'b0, "tear_old_a");
        pulse_load(16'h1111);
        run(7, 15, 32'h82C0C0C0, 1'b0, "tear_old_b");
        run(0, 15, 32'hF9F9F9F9, 1'b0, "tear_new");

        // Load coincident with the boundary edge shows in the frame that follows it.
        run(0, 14, 32'hF9F9F9F9, 1'b0, "bnd_pre");
        bus.data = 16'h4321;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("bnd frame_done", {31'h0, frame_done}, 32'h1);
        run(0, 15, 32'h99B0A4F9, 1'b0, "bnd_load");

        pulse_load(16'hAAAA);
        repeat (3) @(negedge clk);
        pulse_load(16'h5555);
        wait_fd("last_wins");
        run(0, 15, 32'h92929292, 1'b0, "last_wins");

        bus.blink_en = 1'b1;
        run(0, 15, 32'h92929292, 1'b0, "blink_f0");
        run(0, 15, 32'h92929292, 1'b0, "blink_f1");
        run(0, 15, 32'h92929292, 1'b1, "blink_f2");
        bus.blink_en = 1'b0;
        run(0, 15, 32'h92929292, 1'b0, "blink_dis");
        bus.blink_en = 1'b1;
        run(0, 15, 32'h92929292, 1'b0, "blink_f4");
        run(0, 15, 32'h92929292, 1'b0, "blink_f5");
        run(0, 15, 32'h92929292, 1'b1, "blink_f6");
        bus.blink_en = 1'b0;

        // Asynchronous reset mid-digit with a load still pending.
        pulse_load(16'h7777);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async anode", {28'h0, anode}, 32'hF);
        chk("async catode", {24'h0, catode}, 32'hFF);
        chk("async frame_done", {31'h0, frame_done}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run(0, 15, 32'hC0C0C0C0, 1'b0, "rst_frame0");
        run(0, 15, 32'hC0C0C0C0, 1'b0, "rst_frame1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_hex_display.md
MULTI_HEX_DISPLAY -- requirements
Module: multi_hex_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles each digit is held, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: full frames per blink half-period, minimum 1.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 data  input  4*NUM_DIGITS  hex value; nibble i drives digit i (digit 0 rightmost).
REQ-007 load  input  1  one-cycle strobe capturing data into pending register.
REQ-008 state  input  4  processor state code for state mode.
REQ-009 show_state  input  1  when 1, digit NUM_DIGITS-1 displays state instead of its data nibble.
REQ-010 blank_lz  input  1  when 1, leading-zero blanking is enabled.
REQ-011 blink_en  input  1  when 1, the whole display blinks.
REQ-012 dp_mask  input  NUM_DIGITS  bit i lights the decimal point of digit i.
REQ-013 anode  output  NUM_DIGITS  active-low one-hot digit select, registered.
REQ-014 catode  output  8  active-low segments; bit 7 dp, bits 6..0 g..a, registered.
REQ-015 frame_done  output  1  one-cycle pulse at end of each full frame.

Function
REQ-016 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the digit index SHALL advance by 1 on each wrap and roll from NUM_DIGITS-1 to 0.
REQ-017 frame_done SHALL be 1 for exactly the cycle in which the index rolls from NUM_DIGITS-1 to 0 (frame boundary).
REQ-018 load SHALL copy data into the pending register; the display register SHALL take pending only at a frame boundary (no tearing mid-frame).
REQ-019 load coincident with a frame boundary SHALL copy data directly into the display register in that cycle.
REQ-020 Multiple loads within one frame: last one wins.
REQ-021 anode/catode SHALL reflect the current index and display register with one cycle of latency.
REQ-022 Active digit i SHALL drive anode[i]=0, all other anode bits 1.
REQ-023 Segment codes (catode[6:0], hex nibble 0..F) SHALL be 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-024 catode[7] SHALL be ~dp_mask[i] for active digit i, sampled live.
REQ-025 With show_state=1, digit NUM_DIGITS-1 SHALL show state (sampled live); that digit is never leading-zero blanked.
REQ-026 With blank_lz=1, digit i (i>0) SHALL be blanked when it and every displayed data digit above it are 0; digit 0 is never blanked.
REQ-027 Blanked digit: anode still selects it, catode[6:0]=7F; dp still follows dp_mask.
REQ-028 Blink: a frame counter toggles the blink phase every BLINK_FRAMES frame boundaries; with blink_en=1 in the off phase, anode SHALL be all 1s.
REQ-029 blink_en=0 SHALL force the on phase and clear the frame counter.

Reset
REQ-030 reset=0 SHALL immediately set anode all 1s, catode FF, frame_done 0, and clear counters, index, blink phase, and pending/display registers.
REQ-031 Reset mid-frame SHALL discard pending data; after release, the first digit driven is digit 0, one cycle later.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-032 Release reset, load data=16'h12AF -> after next boundary anode cycles E,D,B,7 every 4 clk; catode 8E,88,A4,F9 in order.
REQ-033 load 16'h0005, blank_lz=1 -> digits 3..1 catode FF (dp_mask=0), digit 0 catode 92; blank_lz=0 -> digits 3..1 catode C0.
REQ-034 show_state=1, state=4'h3, data=16'h0007, blank_lz=1 -> digit 3 catode B0, digits 2..1 FF, digit 0 F8.
REQ-035 load 16'h1111 at mid-frame -> old value persists until frame_done, new value from the next digit 0; load on a boundary cycle takes effect that frame.
REQ-036 blink_en=1 -> anode alternates 2 frames active, 2 frames all F; frame_done pulses every 16 clk.
REQ-037 reset=0 asserted asynchronously mid-digit -> anode F, catode FF without a clock edge; pending load lost.
